// File: rtl/sbuf_pkg.sv
// sbuf_pkg: shared sizes and entry type for the store buffer and its forwarding lookup
package sbuf_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW = 64;
  localparam int SB_DW = 64;
  localparam int BYTES = SB_DW / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int LINE_W = SB_AW - OFF_W;
  typedef struct packed {
    logic              valid;
    logic [LINE_W-1:0] line;
    logic [SB_DW-1:0]  data;
    logic [BYTES-1:0]  mask;
  } sbuf_entry_t;
endpackage

// File: rtl/sbuf_fwd_merge.sv
// sbuf_fwd_merge: per-byte youngest-first selection of buffered bytes over a circular entry array
module sbuf_fwd_merge
  import sbuf_pkg::*;
(
  input  sbuf_entry_t [SB_DEPTH-1:0] i_ent,
  input  logic [PTR_W-1:0]           i_head,
  input  logic [PTR_W:0]             i_count,
  input  logic [LINE_W-1:0]          i_line,
  input  logic [BYTES-1:0]           i_mask,
  input  logic [SB_DW-1:0]           i_rd_data,
  output logic [SB_DW-1:0]           o_data,
  output logic [BYTES-1:0]           o_hit
);
  sbuf_entry_t w_e;
  // Walk oldest to youngest so the youngest matching store overwrites earlier picks.
  always_comb begin
    o_data = i_rd_data;
    o_hit = '0;
    w_e = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_e = i_ent[i_head + PTR_W'(k)];
      for (int b = 0; b < BYTES; b++)
        if ((PTR_W+1)'(k) < i_count && w_e.valid && w_e.line == i_line && i_mask[b] && w_e.mask[b]) begin
          o_data[8*b +: 8] = w_e.data[8*b +: 8];
          o_hit[b] = 1'b1;
        end
    end
  end
endmodule

// File: rtl/store_buffer_load_forward.sv
// store_buffer_load_forward: in-order store queue draining to dmem with per-byte load forwarding.
// Define STORE_BUF_COALESCE_EN to merge same-line stores into the youngest entry.
module store_buffer_load_forward
  import sbuf_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int ADDR_WIDTH = SB_AW,
  parameter int DATA_WIDTH = SB_DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [ADDR_WIDTH-1:0]   st_addr,
  input  logic [DATA_WIDTH-1:0]   st_data,
  input  logic [BYTES-1:0]        st_mask,
  output logic                    mem_wr_valid,
  input  logic                    mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [BYTES-1:0]        mem_wr_mask,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  input  logic [BYTES-1:0]        ld_mask,
  input  logic [DATA_WIDTH-1:0]   dmem_rd_data,
  output logic [DATA_WIDTH-1:0]   ld_data,
  output logic [BYTES-1:0]        ld_fwd_hit,
  output logic                    empty
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  sbuf_entry_t [DEPTH-1:0] r_ent;
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0] r_count;
  logic [LINE_W-1:0] w_st_line, w_ld_line;
  logic w_enq, w_drn, w_merge, w_alloc;
  assign w_st_line = LINE_W'(st_addr >> OFF_W);
  assign w_ld_line = LINE_W'(ld_addr >> OFF_W);
  assign st_ready = r_count != FULL;
  assign mem_wr_valid = r_count != '0;
  assign empty = r_count == '0;
  assign w_enq = st_valid & st_ready;
  assign w_drn = mem_wr_valid & mem_wr_ready;
  assign w_alloc = w_enq & ~w_merge;
  assign mem_wr_addr = {r_ent[r_head].line, OFF_W'(0)};
  assign mem_wr_data = r_ent[r_head].data;
  assign mem_wr_mask = r_ent[r_head].mask;
`ifdef STORE_BUF_COALESCE_EN
  logic [PTR_W-1:0] w_yidx;
  logic [DATA_WIDTH-1:0] w_mdata;
  assign w_yidx = r_tail - 1'b1;
  // A lone entry that is draining this edge is already on its way to dmem; merging would lose bytes.
  assign w_merge = w_enq & ~empty & (r_ent[w_yidx].line == w_st_line) & ~(w_drn & (r_count == (PTR_W+1)'(1)));
  always_comb begin
    w_mdata = r_ent[w_yidx].data;
    for (int b = 0; b < BYTES; b++)
      w_mdata[8*b +: 8] = st_mask[b] ? st_data[8*b +: 8] : r_ent[w_yidx].data[8*b +: 8];
  end
`else
  assign w_merge = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
    end else begin
      if (w_drn) r_ent[r_head].valid <= 1'b0;
      if (w_alloc) r_ent[r_tail] <= '{valid: 1'b1, line: w_st_line, data: st_data, mask: st_mask};
`ifdef STORE_BUF_COALESCE_EN
      if (w_merge) begin
        r_ent[w_yidx].data <= w_mdata;
        r_ent[w_yidx].mask <= r_ent[w_yidx].mask | st_mask;
      end
`endif
      r_head <= r_head + PTR_W'(w_drn);
      r_tail <= r_tail + PTR_W'(w_alloc);
      r_count <= r_count + (PTR_W+1)'(w_alloc) - (PTR_W+1)'(w_drn);
    end
  end
  sbuf_fwd_merge u_fwd (
    .i_ent     (r_ent),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_line    (w_ld_line),
    .i_mask    (ld_mask),
    .i_rd_data (dmem_rd_data),
    .o_data    (ld_data),
    .o_hit     (ld_fwd_hit)
  );
endmodule

// File: tb/tb_store_buffer_load_forward.sv
// tb_store_buffer_load_forward: directed and random stimulus against a queue-based model of the store buffer
module tb_store_buffer_load_forward;
  logic clk = 1'b0;
  logic rst, st_valid, st_ready, mem_wr_valid, mem_wr_ready, empty;
  logic [63:0] st_addr, st_data, mem_wr_addr, mem_wr_data, ld_addr, dmem_rd_data, ld_data;
  logic [7:0] st_mask, mem_wr_mask, ld_mask, ld_fwd_hit;
  int checks = 0, errors = 0;
  typedef struct {
    logic [60:0] line;
    logic [63:0] data;
    logic [7:0]  mask;
  } ment_t;
  ment_t q[$];
  always #5 clk = ~clk;
  store_buffer_load_forward dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_mask(st_mask), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
    .ld_addr(ld_addr), .ld_mask(ld_mask), .dmem_rd_data(dmem_rd_data), .ld_data(ld_data),
    .ld_fwd_hit(ld_fwd_hit), .empty(empty)
  );
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  task automatic model_check();
    logic [63:0] ed;
    logic [7:0] eh;
    chk("st_ready", 64'(st_ready), 64'(q.size() != 4));
    chk("mem_wr_valid", 64'(mem_wr_valid), 64'(q.size() != 0));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    if (q.size() != 0) begin
      chk("mem_wr_addr", mem_wr_addr, {q[0].line, 3'b000});
      chk("mem_wr_data", mem_wr_data, q[0].data);
      chk("mem_wr_mask", 64'(mem_wr_mask), 64'(q[0].mask));
    end
    ed = dmem_rd_data;
    eh = '0;
    for (int b = 0; b < 8; b++)
      if (ld_mask[b])
        for (int i = q.size() - 1; i >= 0; i--)
          if (q[i].line == ld_addr[63:3] && q[i].mask[b]) begin
            ed[8*b +: 8] = q[i].data[8*b +: 8];
            eh[b] = 1'b1;
            break;
          end
    chk("ld_data", ld_data, ed);
    chk("ld_fwd_hit", 64'(ld_fwd_hit), 64'(eh));
  endtask
  task automatic step();
    ment_t nq[$];
    ment_t t;
    bit drn, enq, mrg;
    @(negedge clk);
    model_check();
    nq = q;
    if (rst) nq.delete();
    else begin
      drn = q.size() != 0 && mem_wr_ready;
      enq = st_valid && q.size() != 4;
      mrg = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
      mrg = enq && q.size() != 0 && q[q.size()-1].line == st_addr[63:3] && !(drn && q.size() == 1);
`endif
      if (mrg) begin
        t = nq[nq.size()-1];
        for (int b = 0; b < 8; b++)
          if (st_mask[b]) t.data[8*b +: 8] = st_data[8*b +: 8];
        t.mask = t.mask | st_mask;
        nq[nq.size()-1] = t;
      end else if (enq) begin
        t.line = st_addr[63:3];
        t.data = st_data;
        t.mask = st_mask;
        nq.push_back(t);
      end
      if (drn) void'(nq.pop_front());
    end
    @(posedge clk);
    q = nq;
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    st_valid = 1'b1;
    st_addr = a;
    st_data = d;
    st_mask = m;
    step();
    st_valid = 1'b0;
  endtask
  task automatic drain_count(input string name, input int exp);
    int n = 0;
    st_valid = 1'b0;
    mem_wr_ready = 1'b1;
    repeat (6) begin
      if (mem_wr_valid) n++;
      step();
    end
    mem_wr_ready = 1'b0;
    chk(name, 64'(n), 64'(exp));
  endtask
  initial begin
    rst = 1'b1;
    st_valid = 1'b0;
    st_addr = '0;
    st_data = '0;
    st_mask = '0;
    mem_wr_ready = 1'b0;
    ld_addr = '0;
    ld_mask = '0;
    dmem_rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dmem_rd_data = 64'hDEAD_BEEF_0BAD_F00D;
    ld_addr = 64'h100;
    ld_mask = 8'hFF;
    #1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_mem_wr_valid", 64'(mem_wr_valid), 64'd0);
    chk("rst_ld_fwd_hit", 64'(ld_fwd_hit), 64'd0);
    chk("rst_ld_data", ld_data, 64'hDEAD_BEEF_0BAD_F00D);
    step();
    store(64'h100, 64'h1122_3344_5566_7788, 8'hFF);
    #1;
    chk("sd_fwd_data", ld_data, 64'h1122_3344_5566_7788);
    chk("sd_fwd_hit", 64'(ld_fwd_hit), 64'hFF);
    chk("sd_wr_addr", mem_wr_addr, 64'h100);
    step();
    do_reset();
    store(64'h103, 64'h0000_0000_AA00_0000, 8'h08);
    store(64'h103, 64'h0000_0000_BB00_0000, 8'h08);
    dmem_rd_data = '0;
    ld_addr = 64'h103;
    ld_mask = 8'h0F;
    #1;
    chk("sb_fwd_data", ld_data, 64'h0000_0000_BB00_0000);
    chk("sb_fwd_hit", 64'(ld_fwd_hit), 64'h08);
`ifdef STORE_BUF_COALESCE_EN
    drain_count("sb_entries", 1);
`else
    drain_count("sb_entries", 2);
`endif
    do_reset();
    for (int i = 0; i < 4; i++) store(64'h200 + 64'(8 * i), {$urandom, $urandom}, 8'hFF);
    st_valid = 1'b1;
    st_addr = 64'h240;
    st_data = 64'h5555_AAAA_5555_AAAA;
    st_mask = 8'hFF;
    #1;
    chk("full_st_ready", 64'(st_ready), 64'd0);
    step();
    step();
    chk("full_held", 64'(st_ready), 64'd0);
    chk("full_head", mem_wr_addr, 64'h200);
    mem_wr_ready = 1'b1;
    step();
    mem_wr_ready = 1'b0;
    chk("freed_st_ready", 64'(st_ready), 64'd1);
    chk("freed_head", mem_wr_addr, 64'h208);
    step();
    st_valid = 1'b0;
    chk("refull_st_ready", 64'(st_ready), 64'd0);
    do_reset();
    store(64'h300, {$urandom, $urandom}, 8'hFF);
    store(64'h308, {$urandom, $urandom}, 8'hFF);
    mem_wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      st_valid = 1'b1;
      st_addr = 64'h310 + 64'(8 * i);
      st_data = {$urandom, $urandom};
      st_mask = 8'hFF;
      step();
    end
    drain_count("stream_entries", 2);
    do_reset();
    for (int i = 0; i < 3; i++) store(64'h400 + 64'(8 * i), {$urandom, $urandom}, 8'hFF);
    mem_wr_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_empty", 64'(empty), 64'd1);
    chk("midrst_mem_wr_valid", 64'(mem_wr_valid), 64'd0);
    repeat (3) step();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      st_valid = $urandom_range(0, 1) == 1;
      st_addr = 64'h800 + 64'($urandom_range(0, 31));
      st_data = {$urandom, $urandom};
      st_mask = 8'($urandom);
      mem_wr_ready = $urandom_range(0, 2) == 0;
      ld_addr = 64'h800 + 64'($urandom_range(0, 31));
      ld_mask = 8'($urandom);
      dmem_rd_data = {$urandom, $urandom};
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer_load_forward.md
Name: store_buffer_load_forward

Overview:
- Small in-order store queue between the MEM stage and data memory; committed stores enqueue and drain to dmem one per handshake.
- It is the read-side counterpart of store-data forwarding: loads in MEM look up pending stores.
- Each load byte is taken from the youngest matching buffered store; otherwise it comes from dmem read data.
- Removes the RAW hazard between buffered stores and younger loads without stalling the load.

Parameters:
- DEPTH, 4, number of entries; power of 2, minimum 2.
- ADDR_WIDTH, 64, byte address width.
- DATA_WIDTH, 64, store/load data width; BYTES = DATA_WIDTH/8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  MEM stage presents a store
- st_ready  out  1  buffer can accept the store; pipeline stalls when st_valid is high and st_ready is low
- st_addr  in  ADDR_WIDTH  store address; low log2(BYTES) bits ignored, doubleword-aligned line
- st_data  in  DATA_WIDTH  store data, already lane-aligned
- st_mask  in  BYTES  byte enables (sb/sh/sw/sd)
- mem_wr_valid  out  1  head entry valid toward dmem
- mem_wr_ready  in  1  dmem accepts the write
- mem_wr_addr  out  ADDR_WIDTH  head line address, low bits zero
- mem_wr_data  out  DATA_WIDTH  head data
- mem_wr_mask  out  BYTES  head mask
- ld_addr  in  ADDR_WIDTH  load address (line compare only)
- ld_mask  in  BYTES  bytes the load needs
- dmem_rd_data  in  DATA_WIDTH  dmem read data for ld_addr, same cycle
- ld_data  out  DATA_WIDTH  merged load data
- ld_fwd_hit  out  BYTES  per-byte flag: byte came from the buffer
- empty  out  1  no valid entries (fence/ecall drain status)

Behaviour:
- Reset: head=0, tail=0, count=0, all entry valid bits cleared.
- Reset outputs: st_ready=1, mem_wr_valid=0, empty=1, ld_fwd_hit=0.
- Reset mid-operation discards all pending stores; they are not written to dmem.
- Structure: circular FIFO with head/tail pointers of width log2(DEPTH), wrapping DEPTH-1 -> 0, plus count of width log2(DEPTH)+1.
- Enqueue fires when st_valid & st_ready. It writes entry[tail] = {addr, data, mask}, increments tail, and the entry becomes valid at the next edge.
- Drain fires when mem_wr_valid & mem_wr_ready, with mem_wr_valid = count!=0. Head entry fields are driven from registers (no combinational path from st_*). The entry is invalidated and head incremented at the edge.
- st_ready = (count != DEPTH). Full-cycle drain does not free a slot the same cycle (no bypass).
- Simultaneous enqueue and drain: count unchanged; both pointers advance.
- Empty enqueue: mem_wr_valid rises the cycle after enqueue (1-cycle store-to-dmem latency minimum).
- Load lookup is purely combinational over registered valid entries:
  - For each byte b with ld_mask[b], select the youngest valid entry (tail-1 backward to head) with matching line and mask[b].
  - Selected byte goes to ld_data[b] and sets ld_fwd_hit[b]; otherwise ld_data[b] = dmem_rd_data[b] and ld_fwd_hit[b]=0.
  - Bytes not in ld_mask pass dmem_rd_data and have ld_fwd_hit=0.
  - A store enqueuing in the same cycle is NOT visible to lookup. Program order guarantees the older store enqueued earlier.
  - An entry draining this cycle IS still visible, because dmem is updated only at the edge.
- Partial overlap is resolved per byte; no stall is ever generated for loads.
- empty = (count == 0).

Optional Feature:
- Macro STORE_BUF_COALESCE_EN.
- Defined: an enqueue merges into the youngest valid entry instead of allocating when all of the following hold:
  - st_addr line equals that entry's line;
  - that entry is not the head with a drain firing this cycle.
- Merge is per byte: new data overwrites bytes where st_mask=1, and the entry mask becomes OR of old and new masks.
- With merge, count and tail are unchanged, and st_ready is still !full.
- Not defined: every store allocates a new entry.

Decomposition:
- Package sbuf_pkg:
  - localparams BYTES and PTR_W;
  - typedef struct sbuf_entry_t {valid, line addr, data, mask}.
- One sub-module: sbuf_fwd_merge, combinational youngest-first per-byte selection over the entry array, given head/count. It is reusable for a future load queue.

Test Plan:
- Reset then idle -> empty=1, st_ready=1, mem_wr_valid=0, ld_data==dmem_rd_data, ld_fwd_hit=0.
- sd 0x1122334455667788 @0x100 with mem_wr_ready=0, then ld_addr=0x100 mask=0xFF -> ld_data=0x1122334455667788, ld_fwd_hit=0xFF.
- sb 0xAA @0x103 (mask 0x08) then sb 0xBB @0x103, dmem_rd_data=0, load mask 0x0F -> ld_data=0x00000000BB000000, ld_fwd_hit=0x08. With coalesce defined, count=1; without it, count=2.
- Fill 4 stores with mem_wr_ready=0 -> st_ready=0 and a 5th st_valid is held. Raise mem_wr_ready for one cycle -> dmem receives entry 0, and st_ready=1 on the next cycle.
- Continuous st_valid plus mem_wr_ready=1 for 10 cycles -> writes emerge in order across a pointer wrap, and count stays constant.
- rst asserted with 3 entries pending -> next cycle empty=1, mem_wr_valid=0, no further dmem writes.
